fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch front end that produces the `instruction_f` / `pc_f` / `pc_p_four_f` triple consumed by the fetch/decode pipeline register. It owns the program counter and issues in-order requests to instruction memory over a valid/ready request channel with a fixed-order response channel. Returned instructions are buffered in a small FIFO so that decode stalls do not lose words. A redirect from the branch/jump resolution logic flushes the buffer and discards stale in-flight responses.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `DEPTH`, 4, maximum number of instructions outstanding plus buffered; power of two, at least 2.

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_addr` out 32: word-aligned fetch address; equals current PC.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_rsp_valid` in 1: response word valid. Exactly one response per accepted request, in order, no earlier than the cycle after acceptance.
- `imem_rsp_data` in 32: instruction word.
- `stall_d` in 1: decode cannot accept this cycle.
- `redirect_valid` in 1: PC redirect (taken branch/jump).
- `redirect_pc` in 32: redirect target; bits [1:0] ignored (treated as 00).
- `valid_f` out 1: output triple is valid.
- `instruction_f` out 32: fetched instruction.
- `pc_f` out 32: address of `instruction_f`.
- `pc_p_four_f` out 32: `pc_f + 4`, modulo 2^32.

## Operation
- State: PC register; `outstanding` counter (accepted, not yet responded); FIFO of DEPTH entries {instr, pc}; pc-tag FIFO of issued addresses; `drop` counter.
- Request: `imem_req_valid = !rst && (outstanding + fifo_count < DEPTH)`. Both counts are registered values. `imem_req_addr = PC`.
- Request handshake (`valid && ready`): push PC to the tag FIFO, `outstanding++`, `PC <= PC + 4` (wraps 0xFFFF_FFFC -> 0x0000_0000).
- Response: `outstanding--` and pop the tag FIFO. If `drop > 0` or `redirect_valid` this cycle, discard the word and decrement `drop` if it was nonzero. Otherwise push {`imem_rsp_data`, tag} into the FIFO.
- Output: `valid_f = fifo_count != 0`. The outputs show the FIFO head. When `valid_f = 0`, `instruction_f = 32'h0000_0013` (NOP) and `pc_f = pc_p_four_f = 0`.
- Consume: `valid_f && !stall_d && !redirect_valid` pops the head.
- Redirect, which has priority over everything:
  - `PC <= {redirect_pc[31:2], 2'b00}`. The +4 of a same-cycle handshake is overridden, but that request still counts as outstanding.
  - FIFO cleared.
  - `drop <= outstanding_next`. This includes a same-cycle accepted request and excludes a same-cycle response, which is discarded directly.
- Requests after a redirect may issue immediately, subject to credit.
- Invariant: `drop <= outstanding <= DEPTH`; the FIFO never overflows because of the credit check.

## Timing
- Reset (async assert, sync-safe deassert):
  - PC = RESET_PC.
  - `outstanding`, `drop`, and the FIFOs cleared.
  - `imem_req_valid = 0`, `valid_f = 0`, `instruction_f = 32'h13`, `pc_f = 0`, `pc_p_four_f = 0`.
- Reset mid-operation discards all in-flight state. The environment must also reset the memory.
- First request: `imem_req_valid = 1` in the first cycle after `rst` deasserts, with address RESET_PC.
- Latency: a response at edge N is visible on outputs (`valid_f = 1`) after edge N. With a 1-cycle memory, the minimum is request cycle C, response cycle C+1, `valid_f` cycle C+2.
- Throughput: with DEPTH=4, 1-cycle memory latency, and no stall, one instruction per cycle in steady state.
- Stall: outputs are held stable while `stall_d = 1`. Requests continue until credit is exhausted.
- Redirect at cycle R:
  - `valid_f = 0` from R+1.
  - Request for `redirect_pc` issued at R+1 if credit allows.
  - First new instruction appears no earlier than R+3 with a 1-cycle memory.

## Test plan
- Reset, RESET_PC=0x100, 1-cycle memory returning `addr ^ 0xA5A5_0000`, no stall -> `valid_f` from cycle 2 with `pc_f` = 0x100, 0x104, 0x108… consecutive, `pc_p_four_f = pc_f + 4`.
- Hold `stall_d = 1` for 6 cycles mid-stream -> outputs frozen, `imem_req_valid` drops once outstanding + buffered = 4. After release, the sequence resumes with no missing or duplicated PC.
- Redirect to 0x2000 while 2 requests are outstanding and 2 are buffered -> FIFO flushed, the next 2 responses discarded, first valid `pc_f` = 0x2000 with the correct word.
- Redirect in the same cycle as a request handshake, a response, and a consume -> PC loads the target (not target+4), the response is dropped, the head is not delivered, `drop` equals the new outstanding count.
- Variable latency 1–5 cycles with random `imem_req_ready` and `stall_d`; a scoreboard checks in-order, gap-free PC/instruction pairs. Also `redirect_pc` = 0x0000_3003 -> fetch at 0x3000.
- PC wrap: RESET_PC = 0xFFFF_FFF8 -> `pc_f` = 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; `pc_p_four_f` at 0xFFFF_FFFC is 0. Assert `rst` mid-stream -> all outputs return to reset values immediately (asynchronously).

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues in-order imem requests under a credit
// limit, buffers returned words and flushes/drops stale responses on redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall_d,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        valid_f,
    output logic [31:0] instruction_f,
    output logic [31:0] pc_f,
    output logic [31:0] pc_p_four_f
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

    logic [31:0] buf_instr [DEPTH];
    logic [31:0] buf_pc    [DEPTH];
    logic [31:0] tag_mem   [DEPTH];

    logic        req_fire, rsp_drop, buf_push, buf_pop;
    logic [CW:0] credit_used;
    logic        unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Credit covers both in-flight and buffered words so the buffer can never overflow.
    assign credit_used    = {1'b0, outstanding_q} + {1'b0, count_q};
    assign imem_req_valid = !rst && (credit_used < DEPTH_W);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop = (drop_q != '0) || redirect_valid;
    assign buf_push = imem_rsp_valid && !rsp_drop;
    assign valid_f  = (count_q != '0);
    assign buf_pop  = valid_f && !stall_d && !redirect_valid;

    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        count_d       = count_q;
        drop_d        = drop_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;

        if (req_fire) begin
            pc_d     = pc_q + 32'd4;
            tag_wr_d = tag_wr_q + PW'(1);
        end
        if (imem_rsp_valid) begin
            tag_rd_d = tag_rd_q + PW'(1);
        end

        if (req_fire && !imem_rsp_valid) begin
            outstanding_d = outstanding_q + CW'(1);
        end else if (!req_fire && imem_rsp_valid) begin
            outstanding_d = outstanding_q - CW'(1);
        end

        if (imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end

        if (buf_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (buf_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (buf_push && !buf_pop) begin
            count_d = count_q + CW'(1);
        end else if (!buf_push && buf_pop) begin
            count_d = count_q - CW'(1);
        end

        // Every request still in flight after this edge returns a stale word.
        if (redirect_valid) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
            drop_d   = outstanding_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            count_q       <= '0;
            drop_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            count_q       <= count_d;
            drop_q        <= drop_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem[tag_wr_q] <= pc_q;
        end
        if (buf_push) begin
            buf_instr[wr_ptr_q] <= imem_rsp_data;
            buf_pc[wr_ptr_q]    <= tag_mem[tag_rd_q];
        end
    end

    always_comb begin
        instruction_f = 32'h0000_0013;
        pc_f          = '0;
        pc_p_four_f   = '0;
        if (valid_f) begin
            instruction_f = buf_instr[rd_ptr_q];
            pc_f          = buf_pc[rd_ptr_q];
            pc_p_four_f   = buf_pc[rd_ptr_q] + 32'd4;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model of in-flight and buffered fetches,
// driven by directed phases and a randomized variable-latency memory.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH  = 4;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall_d;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        valid_f;
    logic [31:0] instruction_f;
    logic [31:0] pc_f;
    logic [31:0] pc_p_four_f;

    fetch_stage #(
        .RESET_PC(RST_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .stall_d       (stall_d),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .valid_f       (valid_f),
        .instruction_f (instruction_f),
        .pc_f          (pc_f),
        .pc_p_four_f   (pc_p_four_f)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [31:0] pc;
        logic        stale;
    } infl_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } buf_t;

    // Reference model: fetch address, requests in flight (stale once redirected past), buffer.
    logic [31:0] m_pc;
    infl_t       inflight[$];
    buf_t        buffer[$];
    // Memory environment: accepted addresses and the cycle each response is due.
    logic [31:0] mem_addr[$];
    int          mem_due[$];
    int          last_due;
    int          cyc;
    int          checks;
    int          errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_PC;
        inflight.delete();
        buffer.delete();
        mem_addr.delete();
        mem_due.delete();
        last_due = -1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
        chk({tag, "_valid_f"}, {31'b0, valid_f}, 32'd0);
        chk({tag, "_instr"}, instruction_f, 32'h0000_0013);
        chk({tag, "_pc_f"}, pc_f, 32'd0);
        chk({tag, "_pc_p4"}, pc_p_four_f, 32'd0);
    endtask

    // One clock cycle: drive inputs, compare DUT to the model, then advance the model.
    task automatic step(input logic rdy, input logic stl, input logic rdir,
                        input logic [31:0] tgt, input int lat_max);
        logic        rsp, m_req, fire, consume;
        logic [31:0] rdata;
        infl_t       e;
        buf_t        h;
        int          due;
        @(negedge clk);
        rsp   = (mem_due.size() != 0) && (mem_due[0] <= cyc);
        rdata = rsp ? (mem_addr[0] ^ 32'hA5A5_0000) : $urandom;
        imem_req_ready = rdy;
        stall_d        = stl;
        redirect_valid = rdir;
        redirect_pc    = tgt;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rdata;
        #1;
        m_req = (inflight.size() + buffer.size()) < DEPTH;
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, m_req});
        chk("req_addr", imem_req_addr, m_pc);
        if (buffer.size() != 0) begin
            h = buffer[0];
            chk("valid_f", {31'b0, valid_f}, 32'd1);
            chk("instr", instruction_f, h.instr);
            chk("pc_f", pc_f, h.pc);
            chk("pc_p4", pc_p_four_f, h.pc + 32'd4);
        end else begin
            chk("valid_f", {31'b0, valid_f}, 32'd0);
            chk("instr_nop", instruction_f, 32'h0000_0013);
            chk("pc_f_idle", pc_f, 32'd0);
            chk("pc_p4_idle", pc_p_four_f, 32'd0);
        end

        fire    = m_req && rdy;
        consume = (buffer.size() != 0) && !stl && !rdir;
        if (consume) h = buffer.pop_front();
        if (rsp) begin
            e = inflight.pop_front();
            void'(mem_addr.pop_front());
            void'(mem_due.pop_front());
            if (!e.stale && !rdir) begin
                h.instr = rdata;
                h.pc    = e.pc;
                buffer.push_back(h);
            end
        end
        if (fire) begin
            e.pc    = m_pc;
            e.stale = 1'b0;
            inflight.push_back(e);
            due = cyc + int'($urandom_range(lat_max, 1));
            if (due <= last_due) due = last_due + 1;
            mem_addr.push_back(m_pc);
            mem_due.push_back(due);
            last_due = due;
            m_pc     = m_pc + 32'd4;
        end
        if (rdir) begin
            for (int i = 0; i < inflight.size(); i++) begin
                e       = inflight[i];
                e.stale = 1'b1;
                inflight[i] = e;
            end
            buffer.delete();
            m_pc = {tgt[31:2], 2'b00};
        end
        cyc++;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        stall_d        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        model_reset();

        // Reset values, then straight-line fetch across the 32-bit wrap.
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (12) step(1'b1, 1'b0, 1'b0, 32'd0, 1);

        // Decode stall long enough to exhaust credit, then release.
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'd0, 1);
        repeat (8) step(1'b1, 1'b0, 1'b0, 32'd0, 1);

        // Build two buffered + two outstanding, then redirect.
        for (int i = 0; i < 40; i++) begin
            if (inflight.size() == 2 && buffer.size() == 2) break;
            step((buffer.size() == 2) || (inflight.size() + buffer.size() < 2), 1'b1, 1'b0,
                 32'd0, (buffer.size() == 2) ? 5 : 1);
        end
        step(1'b0, 1'b0, 1'b1, 32'h0000_2000, 1);
        repeat (14) step(1'b1, 1'b0, 1'b0, 32'd0, 1);

        // Redirect coinciding with handshake, response and consume in steady stream.
        step(1'b1, 1'b0, 1'b1, 32'h0000_5000, 1);
        @(posedge clk);
        #1;
        chk("redir_same_cycle_pc", imem_req_addr, 32'h0000_5000);
        chk("redir_same_cycle_flush", {31'b0, valid_f}, 32'd0);
        repeat (10) step(1'b1, 1'b0, 1'b0, 32'd0, 1);

        // Misaligned redirect target.
        step(1'b1, 1'b0, 1'b1, 32'h0000_3003, 3);
        @(posedge clk);
        #1;
        chk("redir_align", imem_req_addr, 32'h0000_3000);
        repeat (10) step(1'b1, 1'b0, 1'b0, 32'd0, 3);

        // Randomized ready, stall, redirect and memory latency.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(3, 0) != 0), ($urandom_range(2, 0) == 0),
                 ($urandom_range(19, 0) == 0), $urandom & 32'h000F_FFFF, 5);
        end

        // Asynchronous reset mid-stream.
        repeat (10) step(1'b1, 1'b0, 1'b0, 32'd0, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        stall_d        = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (8) step(1'b1, 1'b0, 1'b0, 32'd0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
